// File: rtl/led_fader_pkg.sv
// LED fader shared definitions.
// Channel count, default PWM width and channel state encoding.
package led_fader_pkg;

    localparam int PWM_BITS_DEF = 8;
    localparam int NUM_CH       = 8;

    typedef enum logic [1:0] {
        IDLE_OFF,
        RISING,
        IDLE_ON,
        FALLING
    } ch_state_t;

endpackage

// File: rtl/led_fader_ch.sv
// One fader channel: saturating level ramp and PWM compare.
// The output register also carries the bypass path.
module led_fader_ch
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS  = PWM_BITS_DEF,
    parameter int RAMP_STEP = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tick_i,
    input  logic                tgt_i,
    input  logic                fade_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o
);

    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [PWM_BITS:0]   STEP = (PWM_BITS+1)'(RAMP_STEP);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS:0]   up, dn;
    logic                led_q, led_d;
    ch_state_t           state;

    // One extra bit catches overflow on the way up and borrow on the way down.
    assign up = {1'b0, level_q} + STEP;
    assign dn = {1'b0, level_q} - STEP;

    // Direction follows the current target, so a reversal starts from the present level.
    always_comb begin
        if (tgt_i) begin
            state = (level_q == MAX) ? IDLE_ON : RISING;
        end else begin
            state = (level_q == '0) ? IDLE_OFF : FALLING;
        end
    end

    // Next level: move one step per ramp tick, clamped at both ends.
    always_comb begin
        level_d = level_q;
        if (tick_i) begin
            unique case (state)
                RISING:   level_d = up[PWM_BITS] ? MAX : up[PWM_BITS-1:0];
                FALLING:  level_d = dn[PWM_BITS] ? '0 : dn[PWM_BITS-1:0];
                IDLE_ON:  level_d = level_q;
                IDLE_OFF: level_d = level_q;
            endcase
        end
    end

    // LED drive: bypass, fully on/off at the ends, else PWM compare.
    always_comb begin
        led_d = 1'b0;
        if (!fade_i) begin
            led_d = tgt_i;
        end else if (level_q == MAX) begin
            led_d = 1'b1;
        end else if (level_q != '0) begin
            led_d = (pwm_cnt_i < level_q);
        end
    end

    // Level and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_fader.sv
// Eight-channel LED fader with shared PWM counter and ramp prescaler.
// Inputs are registered on entry; each channel registers its own output.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS  = PWM_BITS_DEF,
    parameter int RAMP_DIV  = 50000,
    parameter int RAMP_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] pattern_in,
    input  logic              fade_en,
    output logic [NUM_CH-1:0] prled
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

    logic [NUM_CH-1:0]   pat_q;
    logic                fade_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PW-1:0]       pre_q, pre_d;
    logic                tick;

    // Prescaler wraps after RAMP_DIV cycles; a single-cycle divider ticks always.
    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    // Input capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= '0;
            fade_q <= 1'b0;
        end else begin
            pat_q  <= pattern_in;
            fade_q <= fade_en;
        end
    end

    // Free-running PWM counter and ramp prescaler.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
            pre_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            pre_q     <= pre_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_fader_ch #(
            .PWM_BITS  (PWM_BITS),
            .RAMP_STEP (RAMP_STEP)
        ) u_ch (
            .clk_i     (clk),
            .rst_ni    (rst),
            .tick_i    (tick),
            .tgt_i     (pat_q[i]),
            .fade_i    (fade_q),
            .pwm_cnt_i (pwm_cnt_q),
            .led_o     (prled[i])
        );
    end

endmodule
